// File: rtl/vga_fb_pkg.sv
// Shared types and default geometry for the framebuffer pixel source.
// Defaults are derived from the 640x480 timing configuration.
package vga_fb_pkg;

    localparam int DEF_COL_BITS = 4;
    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int DEF_SCALE    = 4;
    localparam int DEF_FB_W     = H_ACTIVE / DEF_SCALE;
    localparam int DEF_FB_H     = V_ACTIVE / DEF_SCALE;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [DEF_COL_BITS-1:0] r;
        logic [DEF_COL_BITS-1:0] g;
        logic [DEF_COL_BITS-1:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_line_buf.sv
// Ping-pong line buffer: two banks of DEPTH entries, bank chosen by
// the address MSB; one write port and one registered read port.
module vga_line_buf #(
    parameter int DEPTH = 160,
    parameter int W     = 4,
    parameter int AW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2][DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr[AW-1]][waddr[AW-2:0]] <= wdata;
        if (re)
            rdata <= mem[raddr[AW-1]][raddr[AW-2:0]];
    end

endmodule

// File: rtl/vga_fb_source.sv
// Palette-indexed framebuffer scan-out with SCALE upscaling, line
// prefetch into a ping-pong buffer and a 2-cycle pixel pipeline.
module vga_fb_source
    import vga_fb_pkg::*;
#(
    parameter int COL_BITS  = DEF_COL_BITS,
    parameter int IDX_BITS  = 4,
    parameter int SCALE     = DEF_SCALE,
    parameter int FB_W      = DEF_FB_W,
    parameter int FB_H      = DEF_FB_H,
    parameter int ADDR_BITS = $clog2(FB_W * FB_H)
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_en,
    input  logic [9:0]            i_x,
    input  logic [9:0]            i_y,
    input  logic                  i_de,
    output logic [COL_BITS-1:0]   o_r,
    output logic [COL_BITS-1:0]   o_g,
    output logic [COL_BITS-1:0]   o_b,
    output logic                  o_de,
    output logic                  o_mem_rd,
    output logic [ADDR_BITS-1:0]  o_mem_addr,
    input  logic [IDX_BITS-1:0]   i_mem_rdata,
    input  logic                  i_pal_we,
    input  logic [IDX_BITS-1:0]   i_pal_addr,
    input  logic [3*COL_BITS-1:0] i_pal_data,
    output logic                  o_underrun
);

    localparam int SH    = $clog2(SCALE);
    localparam int CW    = $clog2(FB_W);
    localparam int PAL_N = 2 ** IDX_BITS;
    localparam int RGB_W = 3 * COL_BITS;

    fetch_state_t         state, state_nx;
    logic [CW-1:0]        col, col_nx;
    logic [ADDR_BITS-1:0] addr_q, addr_nx, next_base;
    logic                 launch, launch_nx;
    logic                 back_valid, bv_nx;
    logic                 front, front_nx;
    logic                 underrun_nx;
    logic                 de_prev, row_start;
    logic [9:0]           y_row, x_col;

    assign y_row     = i_y >> SH;
    assign x_col     = i_x >> SH;
    assign row_start = i_en && i_de && !de_prev
                    && (i_y[SH-1:0] == '0);

    // Last framebuffer row prefetches row 0 for the next frame.
    assign next_base = (y_row >= 10'(FB_H - 1)) ? '0 :
        ADDR_BITS'(y_row + 10'd1) * ADDR_BITS'(FB_W);

    always_comb begin
        state_nx    = state;
        col_nx      = col;
        addr_nx     = addr_q;
        launch_nx   = launch;
        bv_nx       = back_valid;
        front_nx    = front;
        underrun_nx = o_underrun;
        if (row_start) begin
            underrun_nx = o_underrun | (state != IDLE);
            front_nx    = ~front;
            bv_nx       = 1'b0;
            launch_nx   = 1'b0;
            state_nx    = FETCH;
            col_nx      = '0;
            addr_nx     = next_base;
        end else if (launch) begin
            launch_nx = 1'b0;
            state_nx  = FETCH;
            col_nx    = '0;
            addr_nx   = '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (col == CW'(FB_W - 1)) begin
                        state_nx = DRAIN;
                    end else begin
                        col_nx  = col + 1'b1;
                        addr_nx = addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    state_nx = IDLE;
                    bv_nx    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state      <= IDLE;
            col        <= '0;
            addr_q     <= '0;
            launch     <= 1'b1;
            back_valid <= 1'b0;
            front      <= 1'b0;
            o_underrun <= 1'b0;
            de_prev    <= 1'b0;
        end else if (i_en) begin
            state      <= state_nx;
            col        <= col_nx;
            addr_q     <= addr_nx;
            launch     <= launch_nx;
            back_valid <= bv_nx;
            front      <= front_nx;
            o_underrun <= underrun_nx;
            de_prev    <= i_de;
        end
    end

    assign o_mem_rd   = (state == FETCH);
    assign o_mem_addr = addr_q;

    // Return path tracks the memory even while frozen, since a held
    // read strobe keeps returning the word for the held address.
    logic          rd_d;
    logic [CW-1:0] col_d;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            rd_d  <= 1'b0;
            col_d <= '0;
        end else begin
            rd_d  <= o_mem_rd;
            col_d <= col;
        end
    end

    logic                oor, de1, oor1, de_q;
    logic [CW-1:0]       rd_col;
    logic [IDX_BITS-1:0] idx;
    logic [RGB_W-1:0]    rgb_q;
    logic [RGB_W-1:0]    pal [PAL_N];

    assign oor    = x_col >= 10'(FB_W);
    assign rd_col = oor ? '0 : x_col[CW-1:0];

    vga_line_buf #(
        .DEPTH (FB_W),
        .W     (IDX_BITS)
    ) u_line_buf (
        .clk   (i_clk),
        .we    (rd_d),
        .waddr ({~front, col_d}),
        .wdata (i_mem_rdata),
        .re    (i_en),
        .raddr ({front ^ row_start, rd_col}),
        .rdata (idx)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            de1   <= 1'b0;
            oor1  <= 1'b0;
            rgb_q <= '0;
            de_q  <= 1'b0;
        end else if (i_en) begin
            de1   <= i_de;
            oor1  <= oor;
            rgb_q <= (de1 && !oor1) ? pal[idx] : '0;
            de_q  <= de1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            for (int n = 0; n < PAL_N; n++)
                pal[n] <= {3{COL_BITS'(n)}};
        end else if (i_pal_we) begin
            pal[i_pal_addr] <= i_pal_data;
        end
    end

    assign o_r  = i_en ? rgb_q[RGB_W-1 -: COL_BITS] : '0;
    assign o_g  = i_en ? rgb_q[2*COL_BITS-1 -: COL_BITS] : '0;
    assign o_b  = i_en ? rgb_q[COL_BITS-1:0] : '0;
    assign o_de = i_en & de_q;

endmodule

// File: tb/tb_vga_fb_source.sv
// Bench for vga_fb_source: line scenarios from a table against a
// frame-level model of rows, palette and a 2-deep stallable pipe.
module tb_vga_fb_source;
    import vga_fb_pkg::*;

    localparam int FB_W = 160;
    localparam int FB_H = 120;
    localparam int AB   = $clog2(FB_W * FB_H);

    logic          clk = 1'b0;
    logic          i_rstn, i_en, i_de;
    logic [9:0]    i_x, i_y;
    logic [3:0]    o_r, o_g, o_b;
    logic          o_de, o_mem_rd, o_underrun;
    logic [AB-1:0] o_mem_addr;
    logic [3:0]    i_mem_rdata;
    logic          i_pal_we;
    logic [3:0]    i_pal_addr;
    logic [11:0]   i_pal_data;

    always #5 clk = ~clk;

    vga_fb_source dut (
        .i_clk       (clk),
        .i_rstn      (i_rstn),
        .i_en        (i_en),
        .i_x         (i_x),
        .i_y         (i_y),
        .i_de        (i_de),
        .o_r         (o_r),
        .o_g         (o_g),
        .o_b         (o_b),
        .o_de        (o_de),
        .o_mem_rd    (o_mem_rd),
        .o_mem_addr  (o_mem_addr),
        .i_mem_rdata (i_mem_rdata),
        .i_pal_we    (i_pal_we),
        .i_pal_addr  (i_pal_addr),
        .i_pal_data  (i_pal_data),
        .o_underrun  (o_underrun)
    );

    logic [3:0] fb [FB_W*FB_H];

    // Synchronous RAM: word returned the cycle after the strobe.
    always @(posedge clk)
        if (o_mem_rd)
            i_mem_rdata <= fb[o_mem_addr];

    typedef struct {
        int y;
        int len;
        int act;
        int pal_x;
        int off_x;
        bit chk;
        int base;
        bit ur;
    } line_t;

    rgb_t        pal_m [16];
    int          front_row, back_row;
    bit          de_prev_m, chk_pix;
    logic [12:0] s1, s2;
    int          adrq [$];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] pix(input int x, input bit de);
        int c;
        if (!de) return '0;
        c = x / 4;
        if (c >= FB_W) return 13'd1;
        return {pal_m[fb[front_row*FB_W + c]], 1'b1};
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 16; n++)
            pal_m[n] = '{r: 4'(n), g: 4'(n), b: 4'(n)};
        front_row = 0;
        back_row  = 0;
        de_prev_m = 0;
        s1 = '0;
        s2 = '0;
    endtask

    task automatic step(input int x, input int y, input bit de,
                        input bit en, input bit pwe, input bit rec);
        @(negedge clk);
        if (chk_pix)
            check("pixel", {o_r, o_g, o_b, o_de}, i_en ? s2 : 13'd0);
        i_x        = 10'(x);
        i_y        = 10'(y);
        i_de       = de;
        i_en       = en;
        i_pal_we   = pwe;
        i_pal_addr = 4'd3;
        i_pal_data = 12'hF00;
        if (pwe)
            pal_m[3] = rgb_t'(12'hF00);
        if (en) begin
            if (de && !de_prev_m && (y % 4 == 0)) begin
                front_row = back_row;
                back_row  = (y / 4 + 1) % FB_H;
            end
            de_prev_m = de;
            s2 = s1;
            s1 = pix(x, de);
        end
        if (rec && o_mem_rd && en)
            adrq.push_back(int'(o_mem_addr));
    endtask

    task automatic run_line(input line_t t);
        bit en;
        int errs;
        adrq.delete();
        chk_pix = t.chk;
        for (int x = 0; x < t.len; x++) begin
            en = !(t.off_x >= 0 && x >= t.off_x && x < t.off_x + 10);
            step(x, t.y, x < t.act, en, x == t.pal_x, x > 0);
            if (!en)
                check("frozen_addr", o_mem_addr, t.base + t.off_x - 1);
        end
        chk_pix = 1;
        if (t.base >= 0) begin
            check("fetch_count", adrq.size(), 160);
            errs = 0;
            foreach (adrq[i])
                if (adrq[i] != t.base + i) errs++;
            check("fetch_order", errs, 0);
        end
        check("underrun", o_underrun, t.ur);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rstn = 0; i_en = 1; i_de = 0; i_pal_we = 0;
        i_x = '0; i_y = '0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mem_rd", o_mem_rd, 0);
            check("rst_addr", o_mem_addr, 0);
            check("rst_underrun", o_underrun, 0);
            check("rst_pixel", {o_r, o_g, o_b, o_de}, 0);
        end
        @(negedge clk);
        i_rstn = 1;
        i_en   = 0;
    endtask

    line_t tbl [12];
    line_t idle_run, partial;

    initial begin
        for (int a = 0; a < FB_W*FB_H; a++)
            fb[a] = (a < FB_W) ? 4'(a % 16) : 4'($urandom_range(0, 15));
        tbl[0]  = '{0,   800, 640, -1, -1, 1, 160,  0};
        tbl[1]  = '{1,   200, 150, -1, -1, 1, -1,   0};
        tbl[2]  = '{2,   200, 150, -1, -1, 1, -1,   0};
        tbl[3]  = '{3,   200, 150, -1, -1, 1, -1,   0};
        tbl[4]  = '{4,   800, 640, -1, -1, 1, 320,  0};
        tbl[5]  = '{476, 800, 700, -1, -1, 1, 0,    0};
        tbl[6]  = '{8,   800, 640, 13, -1, 1, 480,  0};
        tbl[7]  = '{12,  100, 60,  -1, -1, 1, -1,   0};
        tbl[8]  = '{16,  800, 640, -1, -1, 0, 800,  1};
        tbl[9]  = '{20,  800, 640, -1, -1, 1, 960,  1};
        tbl[10] = '{24,  800, 640, -1, 50, 1, 1120, 1};
        tbl[11] = '{28,  800, 640, -1, -1, 1, 1280, 1};
        idle_run = '{2,  200, 0,   -1, -1, 1, 0,    0};
        partial  = '{32, 80,  60,  -1, -1, 1, -1,   1};
        chk_pix = 1;

        do_reset();
        run_line(idle_run);
        for (int i = 0; i < 12; i++)
            run_line(tbl[i]);
        run_line(partial);
        do_reset();
        run_line(idle_run);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fb_source.md
Name: vga_fb_source

Overview:
- Pixel source that feeds vga_controller in place of test_source.
- Scans out a low-resolution, palette-indexed framebuffer held in external block RAM, upscaled by SCALE in both axes to the active resolution.
- Fetches each framebuffer row into a ping-pong line buffer ahead of display.
- Maps indices through a 16-entry writable RGB palette with fixed 2-cycle pixel latency.

Parameters:
- COL_BITS, 4, bits per colour channel (matches vga_res_cfg_t COL_BITS).
- IDX_BITS, 4, palette index width; palette depth 2**IDX_BITS.
- SCALE, 4, integer upscale factor; power of two.
- FB_W, 160, framebuffer width in pixels (H_ACTIVE/SCALE).
- FB_H, 120, framebuffer height in rows (V_ACTIVE/SCALE).
- ADDR_BITS, $clog2(FB_W*FB_H), framebuffer address width.

Ports:
- i_clk, in, 1, pixel clock.
- i_rstn, in, 1, synchronous active-low reset.
- i_en, in, 1, block enable.
- i_x, in, 10, current pixel column from controller.
- i_y, in, 10, current pixel row from controller.
- i_de, in, 1, active-video qualifier for i_x/i_y.
- o_r / o_g / o_b, out, COL_BITS each, pixel colour.
- o_de, out, 1, i_de delayed to align with colour.
- o_mem_rd, out, 1, framebuffer read strobe.
- o_mem_addr, out, ADDR_BITS, framebuffer read address (row*FB_W+col).
- i_mem_rdata, in, IDX_BITS, read data, valid exactly 1 cycle after o_mem_rd.
- i_pal_we, in, 1, palette write enable.
- i_pal_addr, in, IDX_BITS, palette write index.
- i_pal_data, in, 3*COL_BITS, palette entry {r,g,b}.
- o_underrun, out, 1, sticky: swap occurred while fetch was still busy.

Behaviour:
- Clock and reset: single clock i_clk; reset i_rstn is synchronous and active-low.
- Reset values:
  - o_r/o_g/o_b/o_de/o_mem_rd/o_underrun = 0; o_mem_addr = 0.
  - Palette entry n = {n,n,n} (grayscale ramp; low COL_BITS of n).
  - front=0, back_valid=0.
  - Fetch FSM in IDLE; on the first enabled cycle after reset it launches the fetch of row 0 into the back buffer.
- Line buffer: 2 banks of FB_W x IDX_BITS; front bank is read by display, back bank is written by fetch.
- Fetch FSM: IDLE -> FETCH -> DRAIN -> IDLE.
  - FETCH: o_mem_rd=1 for FB_W consecutive cycles; o_mem_addr = row*FB_W + col, col 0..FB_W-1.
  - DRAIN: 1 cycle to capture the last returned word.
  - Each i_mem_rdata is written to back[col] one cycle after issue.
  - back_valid is set on DRAIN -> IDLE.
  - Fetch duration is FB_W+1 cycles.
- Row-start event: rising edge of i_de (registered previous i_de) with i_y[log2(SCALE)-1:0]==0.
  - front <= ~front; back_valid <= 0.
  - Start fetch of row ((i_y/SCALE)+1) mod FB_H into the new back bank; row FB_H-1 wraps to row 0 for the next frame.
  - If the FSM is not IDLE at a row-start event: set o_underrun, abort the current fetch, swap anyway, restart with the new row.
  - o_underrun clears only on reset.
- Pixel pipeline, latency 2 from i_x/i_y/i_de to o_r/o_g/o_b/o_de:
  - Stage 1: idx <= front[i_x/SCALE]; de1 <= i_de.
  - Stage 2: {o_r,o_g,o_b} <= de1 ? palette[idx] : 0; o_de <= de1.
  - The controller accounts for the 2-cycle latency when aligning sync.
- i_x/SCALE >= FB_W with i_de=1 (out-of-range column): output black.
- Palette write: takes effect the cycle after i_pal_we. A write and a read of the same entry in the same cycle returns the old value.
- i_en=0: FSM, pipeline registers and o_mem_rd frozen; colour outputs forced 0, o_de forced 0. Palette writes still accepted. Row-start events are not detected while disabled.
- Reset mid-fetch: the fetch is abandoned, back_valid=0, and the fetch of row 0 relaunches after reset.

Decomposition:
- Shared package vga_fb_pkg:
  - typedef fetch_state_t {IDLE, FETCH, DRAIN}.
  - typedef rgb_t packed {r,g,b}.
  - Default FB_W/FB_H/SCALE constants derived from the 640x480 config.
- One sub-module: vga_line_buf, a simple dual-port RAM of 2*FB_W entries with 1 write port and 1 registered read port, bank selected by MSB of address.

Test Plan:
- Reset release, no stimulus -> o_mem_rd high for exactly 160 cycles, addresses 0..159 in order; back_valid after cycle 161; o_underrun=0.
- Framebuffer row 0 = index col%16, default palette, i_de rise at y=0, x=0..639 -> o_r=o_g=o_b=(x/4)%16, two cycles after each x; o_de mirrors i_de delayed 2.
- Line y=4 rising i_de -> fetch addresses 320..479 (row 2); line y=476 -> addresses 0..159 (wrap to row 0).
- Write palette[3]={F,0,0} while displaying index 3 -> pixels red from the second cycle after the write; earlier pixels gray 3.
- Row-start events forced 100 cycles apart (short line) -> o_underrun=1, fetch restarts at the new row's base address, o_underrun stays 1 until reset.
- Assert i_en=0 mid-fetch for 10 cycles -> o_mem_addr held, outputs 0; resume completes with all 160 addresses issued exactly once.
